// File: rtl/instruction_memory_loader_if.sv
// Boot-loader byte stream plus the data-path fetch port of the instruction memory.
// master = stream source / data path, slave = instruction_memory_loader.
interface instruction_memory_loader_if #(
    parameter int Instruction_Size   = 32,
    parameter int Program_Count_Size = 32
);
    // A byte moves at a rising edge only when Load_Valid and Load_Ready are both high;
    // Load_Ready never depends on Load_Valid, and Load_Data is ignored otherwise.
    logic [7:0]                    Load_Data;
    logic                          Load_Valid;
    logic                          Load_Ready;
    logic [Program_Count_Size-1:0] PC;
    logic [Instruction_Size-1:0]   Instruction;
    logic                          Core_Hold;
    logic                          Load_Done;
    logic                          Load_Error;

    modport master (
        output Load_Data, Load_Valid, PC,
        input  Load_Ready, Instruction, Core_Hold, Load_Done, Load_Error
    );

    modport slave (
        input  Load_Data, Load_Valid, PC,
        output Load_Ready, Instruction, Core_Hold, Load_Done, Load_Error
    );
endinterface

// File: rtl/instruction_memory_loader.sv
// Instruction memory filled by a big-endian byte-stream boot loader, then read from PC.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module instruction_memory_loader #(
    parameter int Instruction_Size   = 32,
    parameter int Program_Count_Size = 32,
    parameter int Addr_Width         = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    instruction_memory_loader_if.slave bus,
    output logic [2:0]                dbg_state
);
    localparam int Depth = 1 << Addr_Width;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CSUM   = 3'd3,
`endif
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [15:0]                 n_words;
    logic [15:0]                 n_hdr;
    logic [Addr_Width-1:0]       word_idx;
    logic [1:0]                  byte_idx;
    logic [23:0]                 shift;
    logic                        accept;
    logic                        last_byte;
    logic                        loading;
    logic [Instruction_Size-1:0] mem [Depth];
    logic [Program_Count_Size-1:0] pc;
    logic [Addr_Width-1:0]       word_addr;
    logic                        pc_unused;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                  csum;
`endif

    assign accept    = bus.Load_Valid && bus.Load_Ready;
    assign n_hdr     = {n_words[15:8], bus.Load_Data};
    assign last_byte = (byte_idx == 2'd3) &&
                       ({{(16-Addr_Width){1'b0}}, word_idx} == n_words - 16'd1);
    assign dbg_state = state;

    // Byte offset and high PC bits are dropped so fetches wrap modulo the memory depth.
    assign pc        = bus.PC;
    assign word_addr = pc[Addr_Width+1:2];
    assign pc_unused = ^{pc[Program_Count_Size-1:Addr_Width+2], pc[1:0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= HDR_HI;
            n_words  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            shift    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                case (state)
                    HDR_HI: n_words[15:8] <= bus.Load_Data;
                    HDR_LO: n_words[7:0]  <= bus.Load_Data;
                    DATA: begin
                        shift    <= {shift[15:0], bus.Load_Data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) word_idx <= word_idx + Addr_Width'(1);
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ bus.Load_Data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory has no reset: contents survive RST and are only overwritten word by word.
    always_ff @(posedge CLK) begin
        if (accept && state == DATA && byte_idx == 2'd3)
            mem[word_addr_w()] <= {shift, bus.Load_Data};
    end

    function automatic logic [Addr_Width-1:0] word_addr_w();
        return word_idx;
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            HDR_HI: if (accept) state_next = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (n_hdr == 16'd0)               state_next = RUN;
                    else if (int'(n_hdr) > Depth)     state_next = ERR;
                    else                              state_next = DATA;
                end
            end
            DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept && last_byte) state_next = CSUM;
`else
                if (accept && last_byte) state_next = RUN;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: if (accept) state_next = (bus.Load_Data == csum) ? RUN : ERR;
`endif
            default: ;
        endcase
    end

    always_comb begin
        loading = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
`ifdef LOADER_CHECKSUM_EN
        loading = loading || (state == CSUM);
`endif
        bus.Load_Ready  = !RST && loading;
        bus.Core_Hold   = RST || (state != RUN);
        bus.Load_Done   = !RST && (state == RUN);
        bus.Load_Error  = !RST && (state == ERR);
        bus.Instruction = (!RST && state == RUN) ? mem[word_addr] : '0;
    end
endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomised load/fetch bench: stream-position reference model feeding an expected queue.
module tb_instruction_memory_loader;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;
    localparam int W     = 37;  // {instr_dont_care, hold, ready, done, err, instruction}
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] dbg_state;

    always #5 CLK = ~CLK;

    instruction_memory_loader_if #(.Instruction_Size(32), .Program_Count_Size(32)) bus ();

    instruction_memory_loader #(
        .Instruction_Size(32), .Program_Count_Size(32), .Addr_Width(AW)
    ) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave), .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [7:0]  m_rx[$];
    bit          m_rst = 1'b1;

    function automatic int m_n();
        if (m_rx.size() < 2) return 0;
        return int'({m_rx[0], m_rx[1]});
    endfunction

    function automatic int m_total(input int n);
        return 2 + 4 * n + ((CSUM_EN && n > 0) ? 1 : 0);
    endfunction

    function automatic logic [7:0] m_xor(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x ^= m_rx[2 + i];
        return x;
    endfunction

    // {hold, ready, done, err} from how far into the stream we are
    function automatic logic [3:0] m_flags();
        int k;
        int n;
        k = m_rx.size();
        if (m_rst) return 4'b1000;
        if (k < 2) return 4'b1100;
        n = m_n();
        if (n > DEPTH) return 4'b1001;
        if (k < m_total(n)) return 4'b1100;
        if (CSUM_EN && n > 0 && m_rx[k-1] != m_xor(n)) return 4'b1001;
        return 4'b0010;
    endfunction

    task automatic m_accept(input logic [7:0] b);
        int k;
        int n;
        int idx;
        m_rx.push_back(b);
        k = m_rx.size();
        n = m_n();
        if (n <= DEPTH && k >= 6 && k <= 2 + 4 * n && (k - 2) % 4 == 0) begin
            idx = (k - 2) / 4 - 1;
            m_mem[idx]   = {m_rx[k-4], m_rx[k-3], m_rx[k-2], m_rx[k-1]};
            m_known[idx] = 1'b1;
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] mon_e;
    logic [35:0]  mon_a;
    string        mon_t;
    bit           mon_bad;

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            mon_a = {bus.Core_Hold, bus.Load_Ready, bus.Load_Done, bus.Load_Error, bus.Instruction};
            mon_bad = mon_e[36] ? (mon_a[35:32] !== mon_e[35:32]) : (mon_a !== mon_e[35:0]);
            total++;
            if (mon_bad) begin
                bad++;
                $display("FAIL %s: got hold/rdy/done/err=%b instr=%h, want %b instr=%h%s",
                         mon_t, mon_a[35:32], mon_a[31:0], mon_e[35:32], mon_e[31:0],
                         mon_e[36] ? " (instr not checked)" : "");
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic probe(input logic [31:0] pc, input string tag);
        logic [3:0]   f;
        logic [W-1:0] e;
        int           idx;
        bus.PC = pc;
        f   = m_flags();
        idx = int'(pc[AW+1:2]);
        e   = {1'b0, f, 32'h0};
        if (f[1]) begin
            if (m_known[idx]) e[31:0] = m_mem[idx];
            else              e[36]   = 1'b1;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [31:0] pc, input string tag);
        probe(pc, tag);
        tick();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.Load_Valid = 1'b0;
            bus.Load_Data  = 8'($urandom);
            tick();
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input int gmin, input int gmax,
                             input bit chk, input string tag);
        logic [3:0] f;
        idle(int'($urandom_range(gmax, gmin)));
        bus.Load_Valid = 1'b1;
        bus.Load_Data  = b;
        f = m_flags();
        if (chk) probe(bus.PC, tag);
        @(posedge CLK);
        if (f[2]) m_accept(b);
        #1;
        bus.Load_Valid = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        m_rst = 1'b1;
        bus.Load_Valid = 1'b0;
        tick();
        m_rx.delete();
        probe(bus.PC, "in_reset");
        tick();
        RST = 1'b0;
        m_rst = 1'b0;
    endtask

    task automatic load_program(input logic [31:0] words[$], input int gmin, input int gmax,
                                input logic [7:0] csum_flip);
        logic [7:0] b[$];
        logic [7:0] x;
        int         n;
        n = words.size();
        x = 8'h00;
        b.push_back(8'(n >> 8));
        b.push_back(8'(n));
        foreach (words[i]) begin
            for (int j = 3; j >= 0; j--) begin
                b.push_back(words[i][8*j +: 8]);
                x ^= words[i][8*j +: 8];
            end
        end
        if (CSUM_EN && n > 0) b.push_back(x ^ csum_flip);
        foreach (b[i]) push_byte(b[i], gmin, gmax, (i == b.size() - 1), "last_byte_hold");
        check(bus.PC, "hold_after_last");
    endtask

    // ---------------- sequence ----------------
    logic [31:0] prog[$];
    logic [31:0] empty_prog[$];
    int          n_rand;

    initial begin
        bus.PC = '0;
        bus.Load_Valid = 1'b0;
        bus.Load_Data = '0;

        do_reset();
        check(32'h0, "post_reset_ready");

        prog = '{32'h20080005, 32'h01095020};
        load_program(prog, 0, 0, 8'h00);
        check(32'h0, "basic_pc0");
        check(32'h4, "basic_pc4");
        check(32'h104, "basic_wrap");

        do_reset();
        load_program(prog, 1, 1, 8'h00);
        check(32'h0, "alt_gap_pc0");
        check(32'h4, "alt_gap_pc4");

        do_reset();
        push_byte(8'h00, 0, 0, 1'b0, "");
        check(32'h0, "gap_ready");
        push_byte(8'h02, 0, 0, 1'b0, "");
        for (int i = 0; i < 2; i++)
            for (int j = 3; j >= 0; j--) push_byte(prog[i][8*j +: 8], 0, 3, 1'b0, "");
        if (CSUM_EN) push_byte(8'h20 ^ 8'h08 ^ 8'h05 ^ 8'h01 ^ 8'h09 ^ 8'h50 ^ 8'h20, 0, 3, 1'b0, "");
        check(32'h0, "rand_gap_pc0");
        check(32'h4, "rand_gap_pc4");

        for (int it = 0; it < 4; it++) begin
            do_reset();
            prog.delete();
            n_rand = int'($urandom_range(8, 1));
            for (int i = 0; i < n_rand; i++) prog.push_back($urandom);
            load_program(prog, 0, 3, 8'h00);
            check(32'(4 * (n_rand - 1)), "rand_last_word");
            for (int p = 0; p < 3; p++) check($urandom, "rand_pc");
        end

        do_reset();
        load_program(empty_prog, 0, 1, 8'h00);
        check(32'h0, "n0_keeps_pc0");
        check(32'h8, "n0_keeps_pc8");

        do_reset();
        prog.delete();
        for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
        load_program(prog, 0, 0, 8'h00);
        check(32'hFC, "n64_last");
        check(32'h100, "n64_wrap");

        do_reset();
        push_byte(8'h00, 0, 0, 1'b0, "");
        push_byte(8'h41, 0, 0, 1'b0, "");
        check(32'h0, "overflow_err");
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), 0, 1, 1'b0, "");
        check(32'h0, "overflow_sticky");

        do_reset();
        push_byte(8'h00, 0, 0, 1'b0, "");
        push_byte(8'h03, 0, 0, 1'b0, "");
        for (int i = 0; i < 6; i++) push_byte(8'h11 * 8'(i + 1), 0, 1, 1'b0, "");
        do_reset();
        prog = '{32'hAABBCCDD};
        load_program(prog, 0, 0, 8'h00);
        check(32'h0, "midload_pc0");
        check(32'h4, "midload_word1_kept");

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        prog = '{32'h12345678};
        load_program(prog, 0, 1, 8'h00);
        check(32'h0, "csum_good");
        do_reset();
        load_program(prog, 0, 1, 8'h01);
        check(32'h0, "csum_bad");
`endif

        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end
endmodule
